// File: rtl/intarb_pkg.sv
// intarb_pkg: shared definitions for the interrupt arbiter.
//   - interrupt cause numbers
//   - target level and WFI state enums
//   - fixed within-level priority order
//   - level-field width, which depends on INTARB_HYP_EN
package intarb_pkg;

  localparam int INT_SSI  = 1;
  localparam int INT_VSSI = 2;
  localparam int INT_MSI  = 3;
  localparam int INT_STI  = 5;
  localparam int INT_VSTI = 6;
  localparam int INT_MTI  = 7;
  localparam int INT_SEI  = 9;
  localparam int INT_VSEI = 10;
  localparam int INT_MEI  = 11;

  typedef enum logic [1:0] {
    LVL_M  = 2'd0,
    LVL_HS = 2'd1,
    LVL_VS = 2'd2
  } intlevel_t;

  typedef enum logic [1:0] {
    WFI_IDLE = 2'd0,
    WFI_WAIT = 2'd1,
    WFI_TOUT = 2'd2
  } wfistate_t;

  // Standard causes, highest priority first. Bits 16 and up follow these.
  localparam int PRIO_LEN = 9;
  localparam int PRIO_ORDER [PRIO_LEN] = '{INT_MEI, INT_MSI, INT_MTI,
                                           INT_SEI, INT_SSI, INT_STI,
                                           INT_VSEI, INT_VSSI, INT_VSTI};

`ifdef INTARB_HYP_EN
  localparam int LVLW = 2;
`else
  localparam int LVLW = 1;
`endif

  function automatic logic [LVLW-1:0] lvlCode(input intlevel_t lvl);
    return lvl[LVLW-1:0];
  endfunction

endpackage

// File: rtl/intarb_intprio.sv
// intprio: combinational fixed-order priority encoder for one target level.
// Ports:
//   eligible in  NINT : requests already qualified for this level
//   valid    out 1    : some request is selectable
//   cause    out CW   : index of the winning request
// Bits 0, 4, 8 and 12..15 are never selected.
module intprio
  import intarb_pkg::*;
#(
  parameter int NINT = 16,
  parameter int CW   = $clog2(NINT)
) (
  input  logic [NINT-1:0] eligible,
  output logic            valid,
  output logic [CW-1:0]   cause
);

  always_comb begin
    valid = 1'b0;
    cause = '0;
    for (int k = 0; k < PRIO_LEN; k++) begin
      if (!valid && eligible[CW'(PRIO_ORDER[k])]) begin
        valid = 1'b1;
        cause = CW'(PRIO_ORDER[k]);
      end
    end
    for (int i = 16; i < NINT; i++) begin
      if (!valid && eligible[CW'(i)]) begin
        valid = 1'b1;
        cause = CW'(i);
      end
    end
  end

endmodule

// File: rtl/intarb.sv
// intarb: interrupt arbiter and WFI controller.
// Build option: INTARB_HYP_EN enables VS delegation (HIDELEG, VirtModeW,
// VSSTATUS_SIE, TrapToVS). Without it those inputs are ignored, causes
// 2/6/10 are never eligible and TrapToVS is 0.
// Ports:
//   clk, reset (async, active low)
//   StallW, FlushM                 pipeline control
//   MIP, MIE, MIDELEG, HIDELEG     pending / enable / delegation vectors
//   PrivilegeModeW, VirtModeW      current privilege (3=M, 1=S, 0=U) and V
//   STATUS_MIE/SIE, VSSTATUS_SIE   global enables; STATUS_TW timeout-wait
//   InstrValidM, CommittedM/F, wfiM, WfiLimit
//   IntPendingM   any MIP & MIE bit (combinational)
//   InterruptM    take interrupt this cycle; IntCauseM registered cause
//   TrapToM/HS/VS one-hot target while InterruptM
//   WfiStallM, WfiTimeoutM
//
// WFI state | meaning
// ----------+---------------------------------------------
// IDLE      | no WFI in progress
// WAIT      | WFI waiting for a wake, counting cycles
// TOUT      | one-cycle timeout pulse (illegal instruction)
module intarb
  import intarb_pkg::*;
#(
  parameter int NINT = 16,
  parameter int TWW  = 8,
  parameter int CW   = $clog2(NINT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallW,
  input  logic            FlushM,
  input  logic [NINT-1:0] MIP,
  input  logic [NINT-1:0] MIE,
  input  logic [NINT-1:0] MIDELEG,
  input  logic [NINT-1:0] HIDELEG,
  input  logic [1:0]      PrivilegeModeW,
  input  logic            VirtModeW,
  input  logic            STATUS_MIE,
  input  logic            STATUS_SIE,
  input  logic            VSSTATUS_SIE,
  input  logic            STATUS_TW,
  input  logic            InstrValidM,
  input  logic            CommittedM,
  input  logic            CommittedF,
  input  logic            wfiM,
  input  logic [TWW-1:0]  WfiLimit,
  output logic            IntPendingM,
  output logic            InterruptM,
  output logic [CW-1:0]   IntCauseM,
  output logic            TrapToM,
  output logic            TrapToHS,
  output logic            TrapToVS,
  output logic            WfiStallM,
  output logic            WfiTimeoutM
);

  logic            virt, vsSie;
  logic [NINT-1:0] hideleg, pendEn;

`ifdef INTARB_HYP_EN
  assign virt    = VirtModeW;
  assign vsSie   = VSSTATUS_SIE;
  assign hideleg = HIDELEG;
  assign pendEn  = MIP & MIE;
`else
  localparam logic [NINT-1:0] HYP_BITS =
    NINT'((1 << INT_VSSI) | (1 << INT_VSTI) | (1 << INT_VSEI));
  logic unusedHyp;
  assign unusedHyp = ^{HIDELEG, VirtModeW, VSSTATUS_SIE};
  assign virt      = 1'b0;
  assign vsSie     = 1'b0;
  assign hideleg   = '0;
  assign pendEn    = MIP & MIE & ~HYP_BITS;
`endif

  logic privM, privU, enM, enHS, enVS;
  assign privM = (PrivilegeModeW == 2'b11);
  assign privU = (PrivilegeModeW == 2'b00);
  assign enM   = ~privM | STATUS_MIE;
  assign enHS  = ~privM & (virt | privU | STATUS_SIE);
  assign enVS  = virt & (privU | vsSie);

  logic [NINT-1:0] eligM, eligHS, eligVS;
  assign eligM  = pendEn & ~MIDELEG & {NINT{enM}};
  assign eligHS = pendEn & MIDELEG & ~hideleg & {NINT{enHS}};
  assign eligVS = pendEn & MIDELEG & hideleg & {NINT{enVS}};

  logic          mValid, hsValid, vsValid;
  logic [CW-1:0] mCause, hsCause, vsCause;

  intprio #(.NINT(NINT), .CW(CW)) uPrioM (
    .eligible(eligM), .valid(mValid), .cause(mCause));
  intprio #(.NINT(NINT), .CW(CW)) uPrioHS (
    .eligible(eligHS), .valid(hsValid), .cause(hsCause));
  intprio #(.NINT(NINT), .CW(CW)) uPrioVS (
    .eligible(eligVS), .valid(vsValid), .cause(vsCause));

  logic            nextValid;
  logic [CW-1:0]   nextCause;
  logic [LVLW-1:0] nextLevel;

  assign nextValid = mValid | hsValid | vsValid;
  assign nextCause = mValid ? mCause : (hsValid ? hsCause : vsCause);
  assign nextLevel = mValid  ? lvlCode(LVL_M) :
                     hsValid ? lvlCode(LVL_HS) : lvlCode(LVL_VS);

  logic            reqValidQ;
  logic [CW-1:0]   reqCauseQ;
  logic [LVLW-1:0] reqLevelQ;

  // Flush wins over stall so a squashed request never survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqValidQ <= 1'b0;
      reqCauseQ <= '0;
      reqLevelQ <= '0;
    end else if (FlushM) begin
      reqValidQ <= 1'b0;
      reqCauseQ <= '0;
      reqLevelQ <= '0;
    end else if (!StallW) begin
      reqValidQ <= nextValid;
      reqCauseQ <= nextCause;
      reqLevelQ <= nextLevel;
    end
  end

  wfistate_t      state, stateNext;
  logic [TWW-1:0] count, countNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WFI_IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      WFI_IDLE: begin
        if (wfiM & InstrValidM & ~IntPendingM) begin
          stateNext = WFI_WAIT;
          countNext = '0;
        end
      end
      WFI_WAIT: begin
        if (IntPendingM | FlushM) begin
          stateNext = WFI_IDLE;
        end else if (STATUS_TW & ~privM & (count == WfiLimit)) begin
          stateNext = WFI_TOUT;
        end else if (count != {TWW{1'b1}}) begin
          countNext = count + TWW'(1);
        end
      end
      WFI_TOUT: stateNext = WFI_IDLE;
      default:  stateNext = WFI_IDLE;
    endcase
  end

  assign IntPendingM = |(MIP & MIE);
  assign WfiStallM   = (state == WFI_WAIT);
  assign WfiTimeoutM = (state == WFI_TOUT);
  assign InterruptM  = reqValidQ & ~CommittedM & ~CommittedF &
                       (InstrValidM | WfiStallM);
  assign IntCauseM   = reqCauseQ;
  assign TrapToM     = InterruptM & (reqLevelQ == lvlCode(LVL_M));
  assign TrapToHS    = InterruptM & (reqLevelQ == lvlCode(LVL_HS));
`ifdef INTARB_HYP_EN
  assign TrapToVS    = InterruptM & (reqLevelQ == lvlCode(LVL_VS));
`else
  assign TrapToVS    = 1'b0;
`endif

endmodule

// File: tb/tb_intarb.sv
module tb_intarb;
  localparam int NINT = 16;
  localparam int TWW  = 8;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            StallW, FlushM;
  logic [NINT-1:0] MIP, MIE, MIDELEG, HIDELEG;
  logic [1:0]      PrivilegeModeW;
  logic            VirtModeW, STATUS_MIE, STATUS_SIE, VSSTATUS_SIE, STATUS_TW;
  logic            InstrValidM, CommittedM, CommittedF, wfiM;
  logic [TWW-1:0]  WfiLimit;
  logic            IntPendingM, InterruptM, TrapToM, TrapToHS, TrapToVS;
  logic            WfiStallM, WfiTimeoutM;
  logic [CW-1:0]   IntCauseM;

  intarb #(.NINT(NINT), .TWW(TWW)) dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushM(FlushM),
    .MIP(MIP), .MIE(MIE), .MIDELEG(MIDELEG), .HIDELEG(HIDELEG),
    .PrivilegeModeW(PrivilegeModeW), .VirtModeW(VirtModeW),
    .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE),
    .VSSTATUS_SIE(VSSTATUS_SIE), .STATUS_TW(STATUS_TW),
    .InstrValidM(InstrValidM), .CommittedM(CommittedM),
    .CommittedF(CommittedF), .wfiM(wfiM), .WfiLimit(WfiLimit),
    .IntPendingM(IntPendingM), .InterruptM(InterruptM),
    .IntCauseM(IntCauseM), .TrapToM(TrapToM), .TrapToHS(TrapToHS),
    .TrapToVS(TrapToVS), .WfiStallM(WfiStallM), .WfiTimeoutM(WfiTimeoutM)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setInt(input logic [NINT-1:0] bits);
    MIP = bits;
    MIE = bits;
  endtask

  int stallCycles;
  int guard;

  initial begin
    reset = 1'b0; StallW = 0; FlushM = 0;
    MIP = '0; MIE = '0; MIDELEG = '0; HIDELEG = '0;
    PrivilegeModeW = 2'd0; VirtModeW = 0;
    STATUS_MIE = 0; STATUS_SIE = 0; VSSTATUS_SIE = 0; STATUS_TW = 0;
    InstrValidM = 0; CommittedM = 0; CommittedF = 0; wfiM = 0;
    WfiLimit = '0;

    step(2);
    check("rst_int", InterruptM, 0);
    check("rst_cause", IntCauseM, 0);
    check("rst_stall", WfiStallM, 0);
    check("rst_tout", WfiTimeoutM, 0);
    reset = 1'b1;
    step();

    // Reset in the middle of a WFI wait
    wfiM = 1; InstrValidM = 1;
    step();
    wfiM = 0; InstrValidM = 0;
    step(5);
    check("midwait_stall", WfiStallM, 1);
    reset = 1'b0;
    #2;
    check("midwait_rst_stall", WfiStallM, 0);
    check("midwait_rst_tout", WfiTimeoutM, 0);
    check("midwait_rst_int", InterruptM, 0);
    check("midwait_rst_cause", IntCauseM, 0);
    step();
    reset = 1'b1;
    step();

    // S-mode, M-level MEI beats MTI; one-cycle registered latency
    PrivilegeModeW = 2'd1; setInt(16'h0880); MIDELEG = 16'h0200;
    STATUS_SIE = 1; InstrValidM = 1;
    #1;
    check("lat_int_before_edge", InterruptM, 0);
    check("lat_pending", IntPendingM, 1);
    step();
    check("mei_int", InterruptM, 1);
    check("mei_cause", IntCauseM, 11);
    check("mei_tom", TrapToM, 1);
    check("mei_tohs", TrapToHS, 0);
    CommittedF = 1; #1;
    check("committedF_block", InterruptM, 0);
    CommittedF = 0; InstrValidM = 0; #1;
    check("novalid_block", InterruptM, 0);
    InstrValidM = 1;

    // Stall holds the old request
    StallW = 1; setInt(16'h0080);
    step();
    check("stall_hold_cause", IntCauseM, 11);
    StallW = 0;
    step();
    check("stall_release_cause", IntCauseM, 7);

    FlushM = 1;
    step();
    check("flush_int", InterruptM, 0);
    check("flush_cause", IntCauseM, 0);
    FlushM = 0;

    // U-mode HS delegation: SEI beats STI
    PrivilegeModeW = 2'd0; setInt(16'h0220); MIDELEG = 16'h0220;
    step();
    check("hs_cause", IntCauseM, 9);
    check("hs_tohs", TrapToHS, 1);
    check("hs_tom", TrapToM, 0);
    setInt(16'h0228);
    step();
    check("m_over_hs_cause", IntCauseM, 3);
    check("m_over_hs_tom", TrapToM, 1);

    // Reserved bits never selected
    setInt(16'h0111); MIDELEG = '0;
    step();
    check("reserved_int", InterruptM, 0);
    check("reserved_pending", IntPendingM, 1);

    // M-mode never takes an HS-delegated interrupt
    PrivilegeModeW = 2'd3; STATUS_MIE = 1; setInt(16'h0020); MIDELEG = 16'h0020;
    step();
    check("m_ignores_hs", InterruptM, 0);

    // M-mode with MIE clear: pending but not taken, WFI retires at once
    STATUS_MIE = 0; setInt(16'h0080); MIDELEG = '0;
    step();
    check("mmode_mie0_int", InterruptM, 0);
    check("mmode_mie0_pending", IntPendingM, 1);
    wfiM = 1;
    step();
    check("wfi_retire_nostall", WfiStallM, 0);
    wfiM = 0; STATUS_MIE = 1;
    step();
    check("mmode_mie1_int", InterruptM, 1);
    check("mmode_mie1_cause", IntCauseM, 7);

    // Timeout: U-mode, TW=1, limit 3
    setInt('0); PrivilegeModeW = 2'd0; STATUS_MIE = 0; STATUS_TW = 1;
    WfiLimit = 8'd3; wfiM = 1; InstrValidM = 1;
    step();
    wfiM = 0; InstrValidM = 0;
    stallCycles = 0; guard = 0;
    while (WfiStallM && guard < 20) begin
      stallCycles++; guard++;
      step();
    end
    check("tout_stall_cycles", stallCycles, 4);
    check("tout_pulse", WfiTimeoutM, 1);
    step();
    check("tout_pulse_end", WfiTimeoutM, 0);
    check("tout_back_idle", WfiStallM, 0);

    // Wake on the count==limit cycle wins over timeout
    wfiM = 1; InstrValidM = 1;
    step();
    wfiM = 0; InstrValidM = 0;
    step(3);
    check("wake_still_wait", WfiStallM, 1);
    setInt(16'h0080); #1;
    check("wake_pending", IntPendingM, 1);
    step();
    check("wake_stall", WfiStallM, 0);
    check("wake_no_tout", WfiTimeoutM, 0);
    step();
    check("wake_no_tout_later", WfiTimeoutM, 0);

    // Limit 0: timeout one cycle after entering WAIT
    setInt('0); WfiLimit = 8'd0; wfiM = 1; InstrValidM = 1;
    step();
    wfiM = 0; InstrValidM = 0;
    check("lim0_wait", WfiStallM, 1);
    step();
    check("lim0_tout", WfiTimeoutM, 1);
    step();

    // TW=0: wait forever until flush
    STATUS_TW = 0; wfiM = 1; InstrValidM = 1;
    step();
    wfiM = 0; InstrValidM = 0;
    step(6);
    check("tw0_still_wait", WfiStallM, 1);
    check("tw0_no_tout", WfiTimeoutM, 0);
    FlushM = 1;
    step();
    check("tw0_flush_exit", WfiStallM, 0);
    FlushM = 0;

    // VS delegation
    PrivilegeModeW = 2'd0; VirtModeW = 1; MIDELEG = 16'h0400;
    HIDELEG = 16'h0400; setInt(16'h0400); VSSTATUS_SIE = 0;
    STATUS_SIE = 0; InstrValidM = 1;
    step();
`ifdef INTARB_HYP_EN
    check("vs_int", InterruptM, 1);
    check("vs_cause", IntCauseM, 10);
    check("vs_tovs", TrapToVS, 1);
    check("vs_tom", TrapToM, 0);
    CommittedM = 1;
    step();
    check("vs_committed_int", InterruptM, 0);
    check("vs_committed_tovs", TrapToVS, 0);
    CommittedM = 0; #1;
    check("vs_uncommitted_int", InterruptM, 1);
`else
    check("novs_int", InterruptM, 0);
    check("novs_pending", IntPendingM, 1);
    check("novs_tovs", TrapToVS, 0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
